accel_mem_loader: RTL and testbench

ACCEL_MEM_LOADER -- requirements
Module: accel_mem_loader

---
 rtl/accel_mem_loader.sv | 147 ++++++++++++++
 tb/tb_accel_mem_loader.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/accel_mem_loader.sv
// Streams one current block and one search window into two write ports.
// Framing is enforced by s_last_i; a bad frame aborts with a sticky error.
module accel_mem_loader #(
    parameter int CURR_DEPTH   = 256,
    parameter int SEARCH_DEPTH = 1024
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic       s_valid_i,
    output logic       s_ready_o,
    input  logic [7:0] s_data_i,
    input  logic       s_last_i,
    output logic       curr_mem_we_o,
    output logic [7:0] curr_mem_waddr_o,
    output logic [7:0] curr_mem_wdata_o,
    output logic       search_mem_we_o,
    output logic [9:0] search_mem_waddr_o,
    output logic [7:0] search_mem_wdata_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       error_o
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD_CURR,
        LOAD_SEARCH,
        DONE
    } state_e;

    localparam logic [9:0] CURR_LAST   = 10'(CURR_DEPTH - 1);
    localparam logic [9:0] SEARCH_LAST = 10'(SEARCH_DEPTH - 1);

    state_e     state_q, state_d;
    logic [9:0] cnt_q, cnt_d;
    logic       err_q, err_d;
    logic       cwe_q, cwe_d;
    logic [7:0] cwa_q, cwa_d;
    logic [7:0] cwd_q, cwd_d;
    logic       swe_q, swe_d;
    logic [9:0] swa_q, swa_d;
    logic [7:0] swd_q, swd_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        cwe_d   = 1'b0;
        cwa_d   = cwa_q;
        cwd_d   = cwd_q;
        swe_d   = 1'b0;
        swa_d   = swa_q;
        swd_d   = swd_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = LOAD_CURR;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            LOAD_CURR: begin
                if (s_valid_i) begin
                    cwe_d = 1'b1;
                    cwa_d = cnt_q[7:0];
                    cwd_d = s_data_i;
                    if (s_last_i) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CURR_LAST) begin
                        state_d = LOAD_SEARCH;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 10'd1;
                    end
                end
            end
            LOAD_SEARCH: begin
                if (s_valid_i) begin
                    swe_d = 1'b1;
                    swa_d = cnt_q;
                    swd_d = s_data_i;
                    if (cnt_q == SEARCH_LAST) begin
                        cnt_d = '0;
                        if (s_last_i) begin
                            state_d = DONE;
                        end else begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end
                    end else if (s_last_i) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 10'd1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset also clears the strobe of a beat accepted just before it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            cwe_q   <= 1'b0;
            cwa_q   <= '0;
            cwd_q   <= '0;
            swe_q   <= 1'b0;
            swa_q   <= '0;
            swd_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            cwe_q   <= cwe_d;
            cwa_q   <= cwa_d;
            cwd_q   <= cwd_d;
            swe_q   <= swe_d;
            swa_q   <= swa_d;
            swd_q   <= swd_d;
        end
    end

    assign s_ready_o          = (state_q == LOAD_CURR) || (state_q == LOAD_SEARCH);
    assign busy_o             = s_ready_o;
    assign done_o             = (state_q == DONE);
    assign error_o            = err_q;
    assign curr_mem_we_o      = cwe_q;
    assign curr_mem_waddr_o   = cwa_q;
    assign curr_mem_wdata_o   = cwd_q;
    assign search_mem_we_o    = swe_q;
    assign search_mem_waddr_o = swa_q;
    assign search_mem_wdata_o = swd_q;

endmodule

// File: tb/tb_accel_mem_loader.sv
// Directed sequence of randomized loads against a queue-based write model.
// Expected writes are derived from the beat index of every accepted byte.
module tb_accel_mem_loader;

    logic       clk;
    logic       rst_n;
    logic       start_i;
    logic       s_valid_i;
    logic       s_ready_o;
    logic [7:0] s_data_i;
    logic       s_last_i;
    logic       curr_we;
    logic [7:0] curr_waddr;
    logic [7:0] curr_wdata;
    logic       srch_we;
    logic [9:0] srch_waddr;
    logic [7:0] srch_wdata;
    logic       busy_o;
    logic       done_o;
    logic       error_o;

    accel_mem_loader dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .start_i            (start_i),
        .s_valid_i          (s_valid_i),
        .s_ready_o          (s_ready_o),
        .s_data_i           (s_data_i),
        .s_last_i           (s_last_i),
        .curr_mem_we_o      (curr_we),
        .curr_mem_waddr_o   (curr_waddr),
        .curr_mem_wdata_o   (curr_wdata),
        .search_mem_we_o    (srch_we),
        .search_mem_waddr_o (srch_waddr),
        .search_mem_wdata_o (srch_wdata),
        .busy_o             (busy_o),
        .done_o             (done_o),
        .error_o            (error_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int srch;
        int addr;
        int data;
    } wr_t;

    wr_t expq[$];
    wr_t actq[$];
    int  cyc;
    int  start_cyc;
    int  done_cyc;
    int  done_cnt;
    int  both_err;
    int  ready_err;
    int  checks;
    int  passes;

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (curr_we && srch_we) both_err = both_err + 1;
            if (curr_we) actq.push_back('{cyc, 0, int'(curr_waddr), int'(curr_wdata)});
            if (srch_we) actq.push_back('{cyc, 1, int'(srch_waddr), int'(srch_wdata)});
            if (done_o) begin
                done_cnt = done_cnt + 1;
                done_cyc = cyc;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic clear_model();
        expq.delete();
        actq.delete();
        done_cnt  = 0;
        both_err  = 0;
        ready_err = 0;
        done_cyc  = -1;
    endtask

    task automatic cmp_writes(input string tag);
        int bad;
        bad = 0;
        chk({tag, "_nwr"}, actq.size(), expq.size());
        for (int i = 0; i < expq.size() && i < actq.size(); i++) begin
            if (actq[i].cyc != expq[i].cyc || actq[i].srch != expq[i].srch ||
                actq[i].addr != expq[i].addr || actq[i].data != expq[i].data)
                bad++;
        end
        chk({tag, "_wr"}, bad, 0);
        chk({tag, "_both"}, both_err, 0);
        chk({tag, "_ready"}, ready_err, 0);
    endtask

    // Beat b of a load lands in curr[b] for b<256, else search[b-256].
    task automatic run_load(input int nbeats, input int last_at, input bit gaps,
                            input bit incr, input int start_at, input bit start_done,
                            input bit abort);
        int  b;
        int  d;
        b = 0;
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i   = 1'b0;
        start_cyc = cyc;
        while (b < nbeats) begin
            start_i = (b == start_at);
            if (gaps && $urandom_range(0, 2) == 0) begin
                s_valid_i = 1'b0;
                s_last_i  = 1'b0;
                s_data_i  = 8'($urandom);
            end else begin
                d         = incr ? (b % 256) : int'($urandom_range(0, 255));
                s_valid_i = 1'b1;
                s_data_i  = 8'(d);
                s_last_i  = (b == last_at);
                if (s_ready_o !== 1'b1) ready_err++;
                expq.push_back('{cyc + 1, (b >= 256) ? 1 : 0,
                                 (b >= 256) ? b - 256 : b, d});
                b++;
                if (abort && b == nbeats) begin
                    @(posedge clk);
                    #2;
                    rst_n     = 1'b0;
                    s_valid_i = 1'b0;
                    s_last_i  = 1'b0;
                    start_i   = 1'b0;
                    void'(expq.pop_back());
                    return;
                end
            end
            @(negedge clk);
        end
        s_valid_i = 1'b0;
        s_last_i  = 1'b0;
        start_i   = start_done;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    initial begin
        checks    = 0;
        passes    = 0;
        rst_n     = 1'b0;
        start_i   = 1'b0;
        s_valid_i = 1'b0;
        s_data_i  = '0;
        s_last_i  = 1'b0;
        clear_model();
        repeat (3) @(negedge clk);
        rst_n     = 1'b1;
        s_valid_i = 1'b1;
        @(negedge clk);
        chk("rst_ready", s_ready_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_err", error_o, 0);
        chk("rst_cwe", curr_we, 0);
        chk("rst_swe", srch_we, 0);
        s_valid_i = 1'b0;

        clear_model();
        run_load(1280, 1279, 1'b0, 1'b1, -1, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        cmp_writes("full");
        chk("full_done_n", done_cnt, 1);
        chk("full_done_lat", done_cyc - start_cyc, 1280);
        chk("full_err", error_o, 0);
        chk("full_idle", busy_o, 0);

        clear_model();
        run_load(1280, 1279, 1'b1, 1'b0, -1, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        cmp_writes("gaps");
        chk("gaps_done_n", done_cnt, 1);
        chk("gaps_err", error_o, 0);

        clear_model();
        run_load(101, 100, 1'b0, 1'b0, -1, 1'b0, 1'b0);
        s_valid_i = 1'b1;
        repeat (3) @(negedge clk);
        chk("early_ready", s_ready_o, 0);
        s_valid_i = 1'b0;
        @(negedge clk);
        cmp_writes("early");
        chk("early_err", error_o, 1);
        chk("early_busy", busy_o, 0);
        chk("early_done_n", done_cnt, 0);

        clear_model();
        run_load(1280, -1, 1'b1, 1'b0, -1, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        cmp_writes("nolast");
        chk("nolast_err", error_o, 1);
        chk("nolast_done_n", done_cnt, 0);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        chk("restart_err", error_o, 0);
        chk("restart_busy", busy_o, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        clear_model();
        run_load(500, -1, 1'b0, 1'b0, -1, 1'b0, 1'b1);
        #1;
        chk("abort_ready", s_ready_o, 0);
        chk("abort_busy", busy_o, 0);
        chk("abort_done", done_o, 0);
        chk("abort_err", error_o, 0);
        chk("abort_cwe", curr_we, 0);
        chk("abort_swe", srch_we, 0);
        chk("abort_addr", {curr_waddr, srch_waddr}, 0);
        chk("abort_data", {curr_wdata, srch_wdata}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        cmp_writes("abort");

        clear_model();
        run_load(1280, 1279, 1'b1, 1'b0, -1, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        cmp_writes("reload");
        chk("reload_done_n", done_cnt, 1);
        chk("reload_err", error_o, 0);

        clear_model();
        run_load(1280, 1279, 1'b0, 1'b0, 10, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        cmp_writes("ign");
        chk("ign_busy", busy_o, 0);
        chk("ign_done_n", done_cnt, 1);
        chk("ign_done_lat", done_cyc - start_cyc, 1280);
        chk("ign_err", error_o, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
